uart_tx_serializer: RTL and testbench

UART transmit datapath that sits directly downstream of the UART microcoded control unit. It latches a configuration byte and a transmit byte, generates its own bit-rate timing from `Clk`, and shifts out one asynchronous serial frame per accepted `start`. It also returns a per-bit timing pulse (`baud_tick`) and frame status (`busy`, `done`) to the control unit.

---
 rtl/uart_tx_serializer.sv | 109 ++++++++++
 tb/tb_uart_tx_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shifts out one UART frame (start, 8 data LSB first, optional parity, 1-2 stop) per accepted start.
// Config is shadowed at frame accept so mid-frame config writes only affect the next frame.
module uart_tx_serializer #(
  parameter int BASE_DIV = 434,
  parameter int CNT_W    = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       cfg_we,
  input  logic [7:0] cfg_data,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       baud_tick
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t           state_q, state_d;
  logic [6:0]       cfg_q, cfg_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             pen_q, pen_d, podd_q, podd_d, stop2_q, stop2_d;
  logic             tx_q, tx_d, done_q, done_d, tick_q, tick_d;
  logic             unused_cfg;
  assign unused_cfg = cfg_data[7];
  assign tx         = tx_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign baud_tick  = tick_q;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    div_d   = div_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    stop2_d = stop2_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    cfg_d   = cfg_we ? cfg_data[6:0] : cfg_q;
    cnt_d   = (state_q == IDLE || tick_q) ? '0 : cnt_q + CNT_W'(1);
    if (state_q == IDLE && start) begin
      state_d = START;
      data_d  = tx_data;
      div_d   = CNT_W'(BASE_DIV) * (CNT_W'(cfg_q[3:0]) + CNT_W'(1));
      pen_d   = cfg_q[4];
      podd_d  = cfg_q[5];
      stop2_d = cfg_q[6];
      tx_d    = 1'b0;
    end else if (tick_q) begin
      case (state_q)
        START: begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
        DATA: begin
          idx_d   = idx_q + 3'd1;
          state_d = idx_q != 3'd7 ? DATA : pen_q ? PARITY : STOP1;
          tx_d    = idx_q != 3'd7 ? data_q[idx_d] : pen_q ? (^data_q ^ podd_q) : 1'b1;
        end
        PARITY: begin
          state_d = STOP1;
          tx_d    = 1'b1;
        end
        STOP1: begin
          state_d = stop2_q ? STOP2 : IDLE;
          done_d  = !stop2_q;
        end
        default: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      endcase
    end
    // tick is registered: it rises in the last cycle of each bit period
    tick_d = state_d != IDLE && cnt_d == div_d - CNT_W'(1);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      data_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      data_q  <= data_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames with hand-computed bit patterns; a negedge monitor checks tx, ticks and done per frame.
module tb_uart_tx_serializer;
  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx, busy, done, baud_tick;
  typedef struct {
    int         d;
    int         n;
    logic [11:0] bits;
  } frame_t;
  frame_t q[$];
  frame_t cur;
  int n_vec = 0;
  int n_err = 0;
  bit act = 1'b0;
  bit rst_prev = 1'b0;
  int cyc = 0;
  int ticks = 0;
  uart_tx_serializer #(.BASE_DIV(4), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .cfg_we(cfg_we), .cfg_data(cfg_data), .start(start),
    .tx_data(tx_data), .tx(tx), .busy(busy), .done(done), .baud_tick(baud_tick)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // Monitor: pops the expected frame when busy rises and checks every cycle of it
  always @(negedge Clk) begin
    if (Rst) begin
      act = 1'b0;
      if (rst_prev) begin
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", baud_tick, 0);
      end
    end else begin
      if (!act && busy) begin
        chk("frame_queued", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          cur = q.pop_front();
          act = 1'b1;
          cyc = 0;
          ticks = 0;
        end
      end
      if (act) begin
        if (cyc == cur.n * cur.d) begin
          chk("end_done", done, 1);
          chk("end_busy", busy, 0);
          chk("end_tx", tx, 1);
          chk("end_ticks", ticks, cur.n);
          act = 1'b0;
        end else begin
          chk("frame_tx", tx, cur.bits[cyc / cur.d]);
          chk("frame_tick", baud_tick, int'(cyc % cur.d == cur.d - 1));
          chk("frame_done", done, 0);
          ticks += int'(baud_tick);
          cyc++;
        end
      end else begin
        chk("idle_tx", tx, 1);
        chk("idle_done", done, 0);
        chk("idle_tick", baud_tick, 0);
      end
    end
    rst_prev = Rst;
  end
  task automatic tick_n(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic push(input int d, input int n, input logic [11:0] bits);
    frame_t f;
    f.d = d;
    f.n = n;
    f.bits = bits;
    q.push_back(f);
  endtask
  task automatic send(input logic [7:0] v, input int d, input int n, input logic [11:0] bits);
    push(d, n, bits);
    tx_data = v;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
  endtask
  task automatic cfg(input logic [7:0] v);
    cfg_we = 1'b1;
    cfg_data = v;
    tick_n(1);
    cfg_we = 1'b0;
  endtask
  task automatic wait_idle();
    int i = 0;
    while (busy && i < 2000) begin
      tick_n(1);
      i++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int i;
    tick_n(3);
    Rst = 1'b0;
    tick_n(20);
    send(8'h55, 4, 10, 12'h2AA);
    wait_idle();
    tick_n(3);
    cfg(8'h71);
    send(8'h03, 8, 12, 12'hE06);
    wait_idle();
    tick_n(3);
    send(8'h3C, 8, 12, 12'hE78);
    tick_n(20);
    tx_data = 8'hA5;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    tick_n(5);
    cfg(8'h00);
    wait_idle();
    tick_n(2);
    send(8'hA5, 4, 10, 12'h34A);
    wait_idle();
    tick_n(2);
    cfg_we = 1'b1;
    cfg_data = 8'h71;
    send(8'h81, 4, 10, 12'h302);
    cfg_we = 1'b0;
    wait_idle();
    tick_n(2);
    send(8'h81, 8, 12, 12'hF02);
    wait_idle();
    tick_n(2);
    cfg(8'h00);
    push(4, 10, 12'h224);
    push(4, 10, 12'h268);
    tx_data = 8'h12;
    start = 1'b1;
    tick_n(1);
    tx_data = 8'h34;
    i = 0;
    while (!done && i < 200) begin
      tick_n(1);
      i++;
    end
    chk("b2b_done_seen", done, 1);
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_gap_tx", tx, 1);
    tick_n(1);
    chk("b2b_restart_busy", busy, 1);
    chk("b2b_restart_tx", tx, 0);
    start = 1'b0;
    wait_idle();
    tick_n(3);
    cfg(8'h71);
    send(8'h5A, 8, 12, 12'hEB4);
    tick_n(34);
    Rst = 1'b1;
    tick_n(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx", tx, 1);
    tick_n(1);
    Rst = 1'b0;
    tick_n(3);
    send(8'h5A, 4, 10, 12'h2B4);
    wait_idle();
    tick_n(5);
    chk("queue_empty", q.size(), 0);
    chk("monitor_idle", act, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
